// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencing logic.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: drives the PC, runs a single-outstanding request/grant/response
// handshake to instruction memory and holds the fetched word in a one-entry output register.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] PC_Cur,
  output logic        PC_En,
  output logic [31:0] PC_Next,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  input  logic        Stall,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Gnt,
  input  logic        IMem_Rsp_Valid,
  input  logic [31:0] IMem_Rsp_Data,
  output logic        IF_Valid,
  output logic [31:0] IF_Instr,
  output logic [31:0] IF_PC,
  output logic        Misalign_Err
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;

  logic [31:0] r_fetch_addr;
  logic        r_drop;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_misalign;

  logic        w_grant;
  logic        w_load;
  logic        w_redirect;
  logic        w_drop_next;

  assign IMem_Addr    = PC_Cur;
  assign IF_Valid     = r_if_valid;
  assign IF_Instr     = r_if_instr;
  assign IF_PC        = r_if_pc;
  assign Misalign_Err = r_misalign;

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_load       = 1'b0;
    w_redirect   = 1'b0;
    w_drop_next  = r_drop;
    PC_En        = 1'b0;
    PC_Next      = PC_Cur;
    IMem_Req     = 1'b0;

    if (RST_N) begin
      case (r_state)
        BOOT: begin
          PC_En        = 1'b1;
          PC_Next      = RESET_PC;
          w_next_state = REQ;
        end
        REQ: begin
          if (Redirect_Valid) begin
            w_redirect = 1'b1;
          end else begin
            IMem_Req = !r_if_valid || !Stall;
            if (IMem_Req && IMem_Gnt) begin
              w_grant      = 1'b1;
              w_next_state = WAIT;
            end
          end
        end
        WAIT: begin
          if (Redirect_Valid) begin
            // A response landing with the redirect is stale too; otherwise the
            // one still in flight must be dropped when it arrives.
            w_redirect = 1'b1;
            if (IMem_Rsp_Valid) begin
              w_drop_next  = 1'b0;
              w_next_state = REQ;
            end else begin
              w_drop_next = 1'b1;
            end
          end else if (IMem_Rsp_Valid) begin
            w_next_state = REQ;
            if (r_drop) begin
              w_drop_next = 1'b0;
            end else begin
              w_load  = 1'b1;
              PC_En   = 1'b1;
              PC_Next = r_fetch_addr + 32'(INSTR_BYTES);
            end
          end
        end
        default: w_next_state = BOOT;
      endcase

      if (w_redirect) begin
        PC_En   = 1'b1;
        PC_Next = align_word(Redirect_Target);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= BOOT;
      r_drop       <= 1'b0;
      r_fetch_addr <= '0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= NOP_INSTR;
      r_if_pc      <= '0;
      r_misalign   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_drop     <= w_drop_next;
      r_misalign <= w_redirect && (Redirect_Target[1:0] != 2'b00);

      if (w_grant) begin
        r_fetch_addr <= PC_Cur;
      end

      if (w_redirect) begin
        r_if_valid <= 1'b0;
      end else if (w_load) begin
        r_if_valid <= 1'b1;
        r_if_instr <= IMem_Rsp_Data;
        r_if_pc    <= r_fetch_addr;
      end else if (r_if_valid && !Stall) begin
        r_if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller with a PC register model, a one-cycle
// instruction memory model and a scoreboard of expected fetched addresses.
module tb_fetch_controller;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] PC_Cur;
  logic        PC_En;
  logic [31:0] PC_Next;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Target;
  logic        Stall;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Gnt;
  logic        IMem_Rsp_Valid;
  logic [31:0] IMem_Rsp_Data;
  logic        IF_Valid;
  logic [31:0] IF_Instr;
  logic [31:0] IF_PC;
  logic        Misalign_Err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] sb[$];

  logic        hold;
  logic        m_hs;
  logic [31:0] m_addr;
  logic        pend;
  logic [31:0] pend_addr;
  logic        mon_v;
  logic        mon_s;
  logic [31:0] exp_pc;

  fetch_controller #(.RESET_PC(32'h0000_0100)) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .PC_Cur          (PC_Cur),
    .PC_En           (PC_En),
    .PC_Next         (PC_Next),
    .Redirect_Valid  (Redirect_Valid),
    .Redirect_Target (Redirect_Target),
    .Stall           (Stall),
    .IMem_Req        (IMem_Req),
    .IMem_Addr       (IMem_Addr),
    .IMem_Gnt        (IMem_Gnt),
    .IMem_Rsp_Valid  (IMem_Rsp_Valid),
    .IMem_Rsp_Data   (IMem_Rsp_Data),
    .IF_Valid        (IF_Valid),
    .IF_Instr        (IF_Instr),
    .IF_PC           (IF_PC),
    .Misalign_Err    (Misalign_Err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_valid(input int unsigned max_cycles);
    logic seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < max_cycles && !seen; i++) begin
      tick();
      seen = IF_Valid;
    end
    check_eq("wait_valid", 32'(seen), 32'd1);
  endtask

  // Program counter beside the controller
  always @(posedge CLK) begin
    if (!RST_N)     PC_Cur <= 32'h0;
    else if (PC_En) PC_Cur <= PC_Next;
  end

  // Instruction memory: grants at once, answers one cycle later unless held
  initial begin
    IMem_Rsp_Valid = 1'b0;
    IMem_Rsp_Data  = 32'h0;
    pend           = 1'b0;
    pend_addr      = 32'h0;
    forever begin
      @(negedge CLK);
      m_hs   = IMem_Req && IMem_Gnt;
      m_addr = IMem_Addr;
      @(posedge CLK);
      #1;
      IMem_Rsp_Valid = 1'b0;
      if (m_hs) begin
        pend      = 1'b1;
        pend_addr = m_addr;
      end
      if (pend && !hold) begin
        IMem_Rsp_Valid = 1'b1;
        IMem_Rsp_Data  = instr_of(pend_addr);
        pend           = 1'b0;
      end
    end
  end

  // Scoreboard: every newly loaded output word is compared against the queue head
  initial begin
    forever begin
      @(negedge CLK);
      mon_v = IF_Valid;
      mon_s = Stall;
      @(posedge CLK);
      #1;
      if (RST_N && IF_Valid && (!mon_v || !mon_s)) begin
        if (sb.size() == 0) begin
          check_eq("sb_spurious_load", IF_PC, 32'hFFFF_FFFF);
        end else begin
          exp_pc = sb.pop_front();
          check_eq("if_pc", IF_PC, exp_pc);
          check_eq("if_instr", IF_Instr, instr_of(exp_pc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned pe_cnt;
    int unsigned iv_cnt;
    RST_N           = 1'b0;
    Stall           = 1'b0;
    Redirect_Valid  = 1'b0;
    Redirect_Target = 32'h0;
    IMem_Gnt        = 1'b1;
    hold            = 1'b0;
    repeat (3) tick();

    check_eq("rst_if_valid", 32'(IF_Valid), 32'd0);
    check_eq("rst_if_instr", IF_Instr, 32'h0000_0013);
    check_eq("rst_if_pc", IF_PC, 32'h0);
    check_eq("rst_misalign", 32'(Misalign_Err), 32'd0);
    check_eq("rst_pc_en", 32'(PC_En), 32'd0);
    check_eq("rst_req", 32'(IMem_Req), 32'd0);

    // Boot and sequential fetch
    RST_N = 1'b1;
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    sb.push_back(32'h108);
    #1;
    check_eq("boot_pc_en", 32'(PC_En), 32'd1);
    check_eq("boot_pc_next", PC_Next, 32'h100);
    check_eq("boot_req", 32'(IMem_Req), 32'd0);
    tick();
    check_eq("first_pc", PC_Cur, 32'h100);
    check_eq("first_req", 32'(IMem_Req), 32'd1);
    check_eq("first_addr", IMem_Addr, 32'h100);
    pe_cnt = 0;
    iv_cnt = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      pe_cnt += 32'(PC_En);
      iv_cnt += 32'(IF_Valid);
      tick();
    end
    check_eq("seq_pc_en_pulses", pe_cnt, 32'd3);
    check_eq("seq_valid_cycles", iv_cnt, 32'd2);
    check_eq("seq_valid_108", 32'(IF_Valid), 32'd1);

    // Stall for five cycles with the output register full
    Stall = 1'b1;
    #1;
    for (int unsigned i = 0; i < 5; i++) begin
      check_eq("stall_valid", 32'(IF_Valid), 32'd1);
      check_eq("stall_if_pc", IF_PC, 32'h108);
      check_eq("stall_req", 32'(IMem_Req), 32'd0);
      check_eq("stall_pc", PC_Cur, 32'h10C);
      tick();
    end
    Stall = 1'b0;
    sb.push_back(32'h10C);
    #1;
    check_eq("resume_req", 32'(IMem_Req), 32'd1);
    check_eq("resume_addr", IMem_Addr, 32'h10C);
    tick();
    tick();
    check_eq("resume_valid", 32'(IF_Valid), 32'd1);

    // Redirect while the response is still outstanding
    hold = 1'b1;
    #1;
    check_eq("pre_redir_addr", IMem_Addr, 32'h110);
    tick();
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'h200;
    #1;
    check_eq("redir_pc_en", 32'(PC_En), 32'd1);
    check_eq("redir_pc_next", PC_Next, 32'h200);
    check_eq("redir_req", 32'(IMem_Req), 32'd0);
    tick();
    Redirect_Valid = 1'b0;
    hold           = 1'b0;
    #1;
    check_eq("redir_pc", PC_Cur, 32'h200);
    check_eq("redir_valid", 32'(IF_Valid), 32'd0);
    check_eq("drop_wait_req", 32'(IMem_Req), 32'd0);
    tick();
    check_eq("stale_pc_en", 32'(PC_En), 32'd0);
    tick();
    sb.push_back(32'h200);
    check_eq("target_req", 32'(IMem_Req), 32'd1);
    check_eq("target_addr", IMem_Addr, 32'h200);
    check_eq("target_valid0", 32'(IF_Valid), 32'd0);
    tick();
    tick();
    check_eq("target_loaded", 32'(IF_Valid), 32'd1);

    // Misaligned redirect colliding with a response
    tick();
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'h302;
    #1;
    check_eq("mis_pc_en", 32'(PC_En), 32'd1);
    check_eq("mis_pc_next", PC_Next, 32'h300);
    tick();
    Redirect_Valid = 1'b0;
    sb.push_back(32'h300);
    #1;
    check_eq("mis_pc", PC_Cur, 32'h300);
    check_eq("mis_valid", 32'(IF_Valid), 32'd0);
    check_eq("mis_err", 32'(Misalign_Err), 32'd1);
    check_eq("mis_req_addr", IMem_Addr, 32'h300);
    tick();
    check_eq("mis_err_once", 32'(Misalign_Err), 32'd0);
    Stall = 1'b1;
    wait_valid(8);

    // Wrap-around past the top of the address space
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'hFFFF_FFFC;
    sb.push_back(32'hFFFF_FFFC);
    tick();
    Redirect_Valid = 1'b0;
    #1;
    check_eq("wrap_no_mis", 32'(Misalign_Err), 32'd0);
    check_eq("wrap_start_pc", PC_Cur, 32'hFFFF_FFFC);
    wait_valid(8);
    check_eq("wrap_pc", PC_Cur, 32'h0);

    // Reset while a fetch is outstanding
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'h400;
    hold            = 1'b1;
    tick();
    Redirect_Valid = 1'b0;
    #1;
    check_eq("rst_mid_req", 32'(IMem_Req), 32'd1);
    check_eq("rst_mid_addr", IMem_Addr, 32'h400);
    tick();
    RST_N = 1'b0;
    tick();
    hold = 1'b0;
    check_eq("rst2_if_valid", 32'(IF_Valid), 32'd0);
    check_eq("rst2_if_instr", IF_Instr, 32'h0000_0013);
    check_eq("rst2_pc_en", 32'(PC_En), 32'd0);
    check_eq("rst2_req", 32'(IMem_Req), 32'd0);
    tick();
    check_eq("rst2_late_rsp_pc_en", 32'(PC_En), 32'd0);
    RST_N = 1'b1;
    sb.push_back(32'h100);
    #1;
    check_eq("reboot_pc_en", 32'(PC_En), 32'd1);
    check_eq("reboot_pc_next", PC_Next, 32'h100);
    wait_valid(8);
    check_eq("reboot_pc", PC_Cur, 32'h104);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
